// File: rtl/memory_read_arbiter.sv
// N-to-1 arbiter for the memory read handshake: per-channel request capture,
// round-robin grant with cont-chain locking, one downstream request in flight.

module mra_chan #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_cont,
  input  logic                  i_grant,
  input  logic                  i_done,
  output logic                  o_busy,
  output logic                  o_pend,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [LEN_WIDTH-1:0]  o_len,
  output logic                  o_cont
);
  logic                  r_busy, r_pend, r_cont;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;

  // busy covers both pending and in-flight; starts while busy are dropped
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_pend <= 1'b0;
      r_cont <= 1'b0;
      r_addr <= '0;
      r_len  <= '0;
    end else if (i_start && !r_busy) begin
      r_busy <= 1'b1;
      r_pend <= 1'b1;
      r_addr <= i_addr;
      r_len  <= i_len;
      r_cont <= i_cont;
    end else begin
      if (i_grant) r_pend <= 1'b0;
      if (i_done)  r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_len  = r_len;
  assign o_cont = r_cont;
endmodule

module memory_read_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int LOCK_TIMEOUT = 16,
  localparam int GW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] i_ch_addr,
  input  logic [NUM_CHANNELS*LEN_WIDTH-1:0]  i_ch_len,
  input  logic [NUM_CHANNELS-1:0]            i_ch_start,
  input  logic [NUM_CHANNELS-1:0]            i_ch_cont,
  output logic [NUM_CHANNELS-1:0]            o_ch_busy,
  output logic [NUM_CHANNELS-1:0]            o_ch_done,
  output logic [NUM_CHANNELS-1:0]            o_ch_error,
  output logic [ADDR_WIDTH-1:0]              o_m_addr,
  output logic [LEN_WIDTH-1:0]               o_m_len,
  output logic                               o_m_start,
  output logic                               o_m_cont,
  input  logic                               i_m_busy,
  input  logic                               i_m_done,
  input  logic                               i_m_error,
  output logic [GW-1:0]                      o_grant_id
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]                                r_state;
  logic [GW-1:0]                             r_gid, r_rr_ptr, r_lock_ch;
  logic [ADDR_WIDTH-1:0]                     r_m_addr;
  logic [LEN_WIDTH-1:0]                      r_m_len;
  logic                                      r_m_cont, r_lock;
  logic [7:0]                                r_lock_cnt;
  logic [NUM_CHANNELS-1:0]                   r_done, r_err;

  logic [NUM_CHANNELS-1:0]                   w_busy, w_pend, w_cont, w_grant, w_done;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   w_addr;
  logic [NUM_CHANNELS-1:0][LEN_WIDTH-1:0]    w_len;
  logic                                      w_rr_hit, w_lock_pend, w_lock_blk, w_arb;
  logic [GW-1:0]                             w_rr_idx, w_sel;
  logic [GW:0]                               w_j;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_grant[g] = w_arb && (w_sel == GW'(g));
    assign w_done[g]  = (r_state == S_WAIT) && i_m_done && (r_gid == GW'(g));
    mra_chan #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_chan (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_start (i_ch_start[g]),
      .i_addr  (i_ch_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_len   (i_ch_len[g*LEN_WIDTH +: LEN_WIDTH]),
      .i_cont  (i_ch_cont[g]),
      .i_grant (w_grant[g]),
      .i_done  (w_done[g]),
      .o_busy  (w_busy[g]),
      .o_pend  (w_pend[g]),
      .o_addr  (w_addr[g]),
      .o_len   (w_len[g]),
      .o_cont  (w_cont[g])
    );
  end

  // first pending channel at or above rr_ptr; walking down lets the nearest win
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_j      = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      w_j = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_j >= (GW+1)'(NUM_CHANNELS)) w_j = w_j - (GW+1)'(NUM_CHANNELS);
      if (w_pend[w_j[GW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_j[GW-1:0];
      end
    end
  end

  // an idle lock holds off everyone else until its channel returns or it times out
  assign w_lock_pend = r_lock && w_pend[r_lock_ch];
  assign w_lock_blk  = r_lock && !w_pend[r_lock_ch];
  assign w_sel       = w_lock_pend ? r_lock_ch : w_rr_idx;
  assign w_arb       = (r_state == S_IDLE) && !i_m_busy && w_rr_hit && !w_lock_blk;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_gid      <= '0;
      r_rr_ptr   <= '0;
      r_m_addr   <= '0;
      r_m_len    <= '0;
      r_m_cont   <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
      r_lock_cnt <= '0;
      r_done     <= '0;
      r_err      <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_lock_blk) begin
            if (r_lock_cnt == 8'(LOCK_TIMEOUT - 1)) r_lock <= 1'b0;
            else                                    r_lock_cnt <= r_lock_cnt + 8'd1;
          end
          if (w_arb) begin
            r_gid    <= w_sel;
            r_m_addr <= w_addr[w_sel];
            r_m_len  <= w_len[w_sel];
            r_m_cont <= w_cont[w_sel];
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rr_ptr <= (r_gid == GW'(NUM_CHANNELS - 1)) ? '0 : r_gid + 1'b1;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (i_m_done) begin
            r_done[r_gid] <= 1'b1;
            r_err[r_gid]  <= i_m_error;
            r_lock        <= r_m_cont;
            r_lock_ch     <= r_gid;
            r_lock_cnt    <= '0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ch_busy  = w_busy;
  assign o_ch_done  = r_done;
  assign o_ch_error = r_err;
  assign o_m_addr   = r_m_addr;
  assign o_m_len    = r_m_len;
  assign o_m_cont   = r_m_cont;
  assign o_m_start  = (r_state == S_ISSUE);
  assign o_grant_id = r_gid;
endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter: latency, round-robin, lock, timeout,
// stall, error and reset-in-flight, with the downstream engine modelled inline.

module tb_memory_read_arbiter;
  localparam int N = 4, AW = 32, LW = 16, LT = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N*LW-1:0] ch_len  = '0;
  logic [N-1:0]  ch_start = '0, ch_cont = '0;
  logic [N-1:0]  ch_busy, ch_done, ch_error;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic          m_start, m_cont;
  logic          m_busy = 1'b0, m_done = 1'b0, m_error = 1'b0;
  logic [1:0]    grant_id;

  int checks = 0, failures = 0;
  int w, seen;

  memory_read_arbiter #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .LOCK_TIMEOUT(LT)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_ch_addr(ch_addr), .i_ch_len(ch_len), .i_ch_start(ch_start), .i_ch_cont(ch_cont),
    .o_ch_busy(ch_busy), .o_ch_done(ch_done), .o_ch_error(ch_error),
    .o_m_addr(m_addr), .o_m_len(m_len), .o_m_start(m_start), .o_m_cont(m_cont),
    .i_m_busy(m_busy), .i_m_done(m_done), .i_m_error(m_error),
    .o_grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic req(input int ch, input logic [31:0] a, input logic [15:0] l, input logic c);
    ch_start[ch]          = 1'b1;
    ch_addr[ch*AW +: AW]  = a;
    ch_len[ch*LW +: LW]   = l;
    ch_cont[ch]           = c;
  endtask

  task automatic go;
    tick;
    ch_start = '0;
    ch_cont  = '0;
  endtask

  // wait for the grant, check it, complete it, check the completion pulse
  task automatic serve(input int ch, input logic [31:0] ea, input logic [15:0] el,
                       input logic ec, input logic err, output int waited);
    waited = 0;
    while (m_start !== 1'b1 && waited < 60) begin
      tick;
      waited++;
    end
    chk("start_seen", m_start, 1);
    chk("grant_id", grant_id, ch);
    chk("m_addr", m_addr, ea);
    chk("m_len", m_len, el);
    chk("m_cont", m_cont, ec);
    tick;
    chk("start_1cyc", m_start, 0);
    m_done = 1'b1; m_error = err;
    tick;
    m_done = 1'b0; m_error = 1'b0;
    chk("ch_done", ch_done, 64'(1) << ch);
    chk("ch_error", ch_error, 64'(err) << ch);
    chk("busy_clr", ch_busy[ch], 0);
  endtask

  initial begin
    tick; tick;
    chk("rst_busy", ch_busy, 0);
    chk("rst_done", ch_done, 0);
    chk("rst_error", ch_error, 0);
    chk("rst_start", m_start, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_len", m_len, 0);
    chk("rst_cont", m_cont, 0);
    chk("rst_gid", grant_id, 0);
    rst = 1'b0;

    // single request, nominal latency
    req(2, 32'h1000, 16'd64, 1'b0);
    go;
    chk("t1_busy", ch_busy, 4'b0100);
    chk("t1_nostart", m_start, 0);
    serve(2, 32'h1000, 16'd64, 1'b0, 1'b0, w);
    chk("t1_latency", w, 1);
    tick;
    chk("t1_done_1cyc", ch_done, 0);

    // round-robin from a fresh pointer
    rst = 1'b1; tick; rst = 1'b0;
    req(0, 32'h100, 16'd1, 1'b0);
    req(1, 32'h200, 16'd2, 1'b0);
    req(3, 32'h300, 16'd3, 1'b0);
    go;
    chk("t2_busy", ch_busy, 4'b1011);
    serve(0, 32'h100, 16'd1, 1'b0, 1'b0, w);
    serve(1, 32'h200, 16'd2, 1'b0, 1'b0, w);
    chk("t2_b2b_wait", w, 1);
    serve(3, 32'h300, 16'd3, 1'b0, 1'b0, w);
    req(0, 32'h400, 16'd4, 1'b0);
    req(3, 32'h500, 16'd5, 1'b0);
    go;
    serve(0, 32'h400, 16'd4, 1'b0, 1'b0, w);
    serve(3, 32'h500, 16'd5, 1'b0, 1'b0, w);

    // cont lock keeps ch1 ahead of ch2 even though rr_ptr points at ch2
    req(1, 32'h600, 16'd6, 1'b1);
    go;
    serve(1, 32'h600, 16'd6, 1'b1, 1'b0, w);
    req(1, 32'h700, 16'd7, 1'b0);
    req(2, 32'h800, 16'd8, 1'b0);
    go;
    serve(1, 32'h700, 16'd7, 1'b0, 1'b0, w);
    serve(2, 32'h800, 16'd8, 1'b0, 1'b0, w);

    // lock timeout: ch0 waits out 16 idle cycles of ch1's lock
    req(1, 32'h900, 16'd9, 1'b1);
    go;
    serve(1, 32'h900, 16'd9, 1'b1, 1'b0, w);
    req(0, 32'hA00, 16'd10, 1'b0);
    go;
    serve(0, 32'hA00, 16'd10, 1'b0, 1'b0, w);
    chk("t4_lock_wait", w, 16);

    // downstream stall, ignored restart while busy, error completion
    m_busy = 1'b1;
    req(3, 32'hB00, 16'd11, 1'b0);
    go;
    seen = 0;
    req(3, 32'hC00, 16'd12, 1'b1);
    if (m_start) seen++;
    go;
    repeat (9) begin
      if (m_start) seen++;
      tick;
    end
    chk("t5_stall", seen, 0);
    chk("t5_busy", ch_busy, 4'b1000);
    m_busy = 1'b0;
    serve(3, 32'hB00, 16'd11, 1'b0, 1'b1, w);

    // reset while WAIT abandons the transfer and rewinds rr_ptr
    req(2, 32'hD00, 16'd13, 1'b0);
    go;
    tick;
    chk("t6_start", m_start, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_busy", ch_busy, 0);
    chk("t6_start_clr", m_start, 0);
    chk("t6_done", ch_done, 0);
    chk("t6_gid", grant_id, 0);
    m_done = 1'b1;
    tick;
    m_done = 1'b0;
    chk("t6_stray_done", ch_done, 0);
    tick;
    chk("t6_stray_done2", ch_done, 0);
    req(1, 32'hE00, 16'd14, 1'b0);
    req(3, 32'hF00, 16'd15, 1'b0);
    go;
    serve(1, 32'hE00, 16'd14, 1'b0, 1'b0, w);
    serve(3, 32'hF00, 16'd15, 1'b0, 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_read_arbiter.md
# memory_read_arbiter

Parametrised N-to-1 arbiter for the memory read request handshake (addr/len/start/cont/busy/done/error). It sits between NUM_CHANNELS independent read masters (DMA channels, descriptor fetchers) and a single memory read engine. Each channel gets its own slave-side port, and one request is outstanding downstream at a time. Grants are round-robin, except that a `cont` chain keeps the grant on its channel so that merged transfers are not interleaved.

## Interface
- NUM_CHANNELS, 4, number of upstream channels (1..16)
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 16, transfer length width
- LOCK_TIMEOUT, 16, idle cycles after which a `cont` lock is dropped (1..255)
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ch_addr  in  NUM_CHANNELS*ADDR_WIDTH  per-channel address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_len  in  NUM_CHANNELS*LEN_WIDTH  per-channel length, same packing
- ch_start  in  NUM_CHANNELS  request strobe per channel
- ch_cont  in  NUM_CHANNELS  merge-with-next flag, sampled with ch_start
- ch_busy  out  NUM_CHANNELS  channel has a pending or in-flight request
- ch_done  out  NUM_CHANNELS  one-cycle completion pulse per channel
- ch_error  out  NUM_CHANNELS  error status, valid only with ch_done
- m_addr  out  ADDR_WIDTH  downstream address
- m_len  out  LEN_WIDTH  downstream length
- m_start  out  1  downstream request strobe
- m_cont  out  1  downstream merge flag
- m_busy  in  1  downstream engine busy
- m_done  in  1  downstream completion
- m_error  in  1  downstream error, valid with m_done
- grant_id  out  max(1,$clog2(NUM_CHANNELS))  index of the last or current granted channel (debug)

## Operation
- Request capture
  - Channel i's start is accepted when ch_start[i]=1 and ch_busy[i]=0.
  - On acceptance, addr, len and cont are latched into a per-channel request register, the pending bit is set, and ch_busy[i]=1 from the next cycle.
  - ch_start[i] while ch_busy[i]=1 is ignored, and the latched values are unchanged.
- The FSM has three states: IDLE, ISSUE and WAIT.
- IDLE
  - The FSM arbitrates when any pending bit is set and m_busy=0.
  - Selection: if a lock is active and the locked channel is pending, that channel is chosen. Otherwise the first pending channel searching upward from rr_ptr (modulo NUM_CHANNELS) is chosen.
  - The winner is registered into grant_id and m_addr/m_len/m_cont, its pending bit is cleared, and the FSM moves to ISSUE.
- ISSUE
  - m_start=1 for exactly one cycle, then WAIT.
  - rr_ptr becomes grant_id+1, wrapping to 0.
- WAIT
  - The FSM waits for m_done and ignores m_busy.
  - On m_done: ch_done[grant_id]=1 and ch_error[grant_id]=m_error, registered and one-cycle.
  - In the same cycle ch_busy[grant_id]=0 and the FSM returns to IDLE.
- Lock
  - After a granted request with cont=1 completes, lock is set on that channel and the lock counter is cleared.
  - A granted request with cont=0 clears the lock at completion.
  - While lock is active and the locked channel is not pending, the counter increments each IDLE cycle. At LOCK_TIMEOUT the lock is dropped and normal round-robin resumes.
- m_done outside WAIT is ignored.
- Reset
  - Clears pending, lock, lock counter and rr_ptr (0), and sets the FSM to IDLE.
  - Reset mid-transfer abandons the in-flight request with no ch_done. The downstream engine shares this reset.

## Timing
- Reset values: ch_busy=0, ch_done=0, ch_error=0, m_start=0, m_cont=0, m_addr=0, m_len=0, grant_id=0.
- Request path: ch_start accepted at cycle t → ch_busy=1 at t+1 → arbitration at t+1 (if IDLE, m_busy=0) → m_start=1 at t+2, with m_addr/m_len/m_cont stable from t+2 until the next grant.
- Completion path: m_done at cycle d → ch_done=1 and ch_busy=0 at d+1 → FSM in IDLE at d+1 → earliest next m_start at d+2.
- Back-to-back: a channel may assert ch_start at d+1 (busy already 0). The request is accepted and can be granted at d+2, with m_start at d+3.
- Simultaneous starts on several channels in one cycle are all captured and served in round-robin order.
- m_busy=1 in IDLE stalls arbitration. Pending requests are held and nothing is lost.
- ch_error is 0 whenever ch_done is 0.

## Test plan
- Single request: ch2 start with addr=0x1000, len=64 at t → m_start at t+2 with m_addr=0x1000, m_len=64. m_done with m_error=0 → ch_done[2]=1 one cycle later, ch_busy[2]=0.
- Round-robin: ch0, ch1 and ch3 start in the same cycle → grants 0,1,3. Then ch0 and ch3 start again → grants 0,3 (rr_ptr=0 after 3).
- Lock: ch1 issues with cont=1 and completes; ch1 and ch2 are then both pending → ch1 is granted first. ch1 then issues with cont=0 → after completion ch2 is granted.
- Lock timeout (LOCK_TIMEOUT=16): ch1 completes with cont=1; ch0 is pending and ch1 stays idle → ch0 is granted after exactly 16 idle cycles, not earlier.
- Error and stall: hold m_busy=1 for 10 cycles with ch3 pending → no m_start during the stall. Then m_done with m_error=1 → ch_error[3]=1 coincident with ch_done[3].
- Reset in WAIT: reset asserted mid-transfer → next cycle all ch_busy=0, m_start=0, no ch_done pulse. A new request afterwards is granted normally, starting from rr_ptr=0.
